// File: rtl/game_timer_ctrl.sv
// game_timer_ctrl: BCD MM:SS round countdown with start/pause/abort sequencing and expiry pulse.
module game_timer_ctrl #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        pause,
    input  logic        abort,
    input  logic [15:0] preset,
    output logic [15:0] times,
    output logic        stop_state,
    output logic        time_out,
    output logic        expired,
    output logic [1:0]  state
);
    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

    state_t        state_q, state_d;
    logic [15:0]   times_q, times_d, dec;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          time_out_q, time_out_d, stop_state_q, stop_state_d, expired_q, expired_d;
    logic          start_ok;

    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [15:0] r;
        r = t;
        if (t[3:0] != 4'd0) r[3:0] = t[3:0] - 4'd1;
        else begin
            r[3:0] = 4'd9;
            if (t[7:4] != 4'd0) r[7:4] = t[7:4] - 4'd1;
            else begin
                r[7:4] = 4'd5;
                if (t[11:8] != 4'd0) r[11:8] = t[11:8] - 4'd1;
                else begin
                    r[11:8]  = 4'd9;
                    r[15:12] = t[15:12] - 4'd1;
                end
            end
        end
        return r;
    endfunction

    assign start_ok = start && preset[15:12] <= 4'd9 && preset[11:8] <= 4'd9 &&
                      preset[7:4] <= 4'd5 && preset[3:0] <= 4'd9 && preset != 16'h0000;
    assign dec = bcd_dec(times_q);

    always_comb begin
        state_d    = state_q;
        times_d    = times_q;
        cnt_d      = cnt_q;
        time_out_d = 1'b0;
        if (abort) begin
            state_d = IDLE;
            times_d = 16'h0000;
            cnt_d   = '0;
        end else if (start_ok) begin
            state_d = RUN;
            times_d = preset;
            cnt_d   = '0;
        end else begin
            case (state_q)
                RUN: begin
                    // A pause on the tick cycle freezes cnt at LAST so the tick fires right after resume.
                    if (pause) state_d = PAUSED;
                    else if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        times_d = dec;
                        if (dec == 16'h0000) begin
                            state_d    = EXPIRED;
                            time_out_d = 1'b1;
                        end
                    end else cnt_d = cnt_q + 1'b1;
                end
                PAUSED:  state_d = pause ? RUN : PAUSED;
                default: ;
            endcase
        end
        stop_state_d = state_d != RUN;
        expired_d    = state_d == EXPIRED;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            times_q      <= 16'h0000;
            cnt_q        <= '0;
            time_out_q   <= 1'b0;
            stop_state_q <= 1'b1;
            expired_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            times_q      <= times_d;
            cnt_q        <= cnt_d;
            time_out_q   <= time_out_d;
            stop_state_q <= stop_state_d;
            expired_q    <= expired_d;
        end
    end

    assign times      = times_q;
    assign state      = state_q;
    assign time_out   = time_out_q;
    assign stop_state = stop_state_q;
    assign expired    = expired_q;
endmodule
